// File: rtl/comp_serial_unit.sv
// Multi-cycle magnitude comparator: scans captured operands CHUNK bits per cycle,
// MSB first, stopping at the first differing chunk. Registered eq/lt/gt plus legacy z.
module comp_serial_unit #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] R1,
  input  logic [WIDTH-1:0] R2,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt,
  output logic             z
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             smode_q, smode_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;

  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic             sign_split;

  // Chunk idx counted from the MSB end; a right shift keeps the select lint-clean.
  function automatic logic [CHUNK-1:0] get_chunk(input logic [WIDTH-1:0] v,
                                                 input logic [IDXW-1:0]  idx);
    logic [31:0] sh;
    sh = 32'(WIDTH - CHUNK) - 32'(idx) * 32'(CHUNK);
    return CHUNK'(v >> sh);
  endfunction

  assign chunk_a    = get_chunk(a_q, idx_q);
  assign chunk_b    = get_chunk(b_q, idx_q);
  assign sign_split = smode_q && (idx_q == '0) && (a_q[WIDTH-1] != b_q[WIDTH-1]);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      smode_q <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      smode_q <= smode_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    smode_d = smode_q;
    done_d  = 1'b0;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = R1;
          b_d     = R2;
          smode_d = signed_mode;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // With equal sign bits, unsigned chunk order is also the signed order.
        if (sign_split) begin
          eq_d    = 1'b0;
          lt_d    = a_q[WIDTH-1];
          gt_d    = ~a_q[WIDTH-1];
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (chunk_a != chunk_b) begin
          eq_d    = 1'b0;
          lt_d    = (chunk_a < chunk_b);
          gt_d    = (chunk_a > chunk_b);
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (idx_q == LAST_IDX) begin
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == SCAN);
  assign done = done_q;
  assign eq   = eq_q;
  assign lt   = lt_q;
  assign gt   = gt_q;
  assign z    = eq_q;

endmodule

// File: tb/tb_comp_serial_unit.sv
// Scoreboard bench for comp_serial_unit: driver pushes expected results, monitor pops on done.
module tb_comp_serial_unit;
  localparam int W   = 8;
  localparam int C   = 2;
  localparam int NCH = W / C;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         start = 1'b0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] R1 = '0;
  logic [W-1:0] R2 = '0;
  logic         busy, done, eq, lt, gt, z;

  comp_serial_unit #(.WIDTH(W), .CHUNK(C)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .start(start), .signed_mode(signed_mode),
    .R1(R1), .R2(R2), .busy(busy), .done(done),
    .eq(eq), .lt(lt), .gt(gt), .z(z)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic eq;
    logic lt;
    logic gt;
    int   due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errs   = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: integer compare for the flags; latency from the first differing chunk.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sm, input int now);
    exp_t   e;
    longint va, vb;
    int     lat;
    int     ca, cb;
    va = sm ? longint'($signed(a)) : longint'(a);
    vb = sm ? longint'($signed(b)) : longint'(b);
    e.eq = (va == vb);
    e.lt = (va < vb);
    e.gt = (va > vb);
    lat = NCH;
    if (sm && (a[W-1] != b[W-1])) lat = 1;
    else begin
      for (int i = NCH - 1; i >= 0; i--) begin
        ca = int'(a >> (W - (i + 1) * C)) & ((1 << C) - 1);
        cb = int'(b >> (W - (i + 1) * C)) & ((1 << C) - 1);
        if (ca != cb) lat = i + 1;
      end
    end
    e.due = now + 1 + lat;
    return e;
  endfunction

  task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sm);
    @(negedge Clk);
    start = s; R1 = a; R2 = b; signed_mode = sm;
    if (s && !busy && Rst_n) sb.push_back(model(a, b, sm, cyc));
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      drive(1'b0, R1, R2, signed_mode);
      n++;
    end while ((busy || sb.size() != 0) && n < 40);
    chk("wait_idle_timeout", int'(n >= 40), 0);
  endtask

  always @(negedge Clk) begin
    if (Rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL spurious_done: done=1 with no outstanding request (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("eq", int'(eq), int'(e.eq));
        chk("lt", int'(lt), int'(e.lt));
        chk("gt", int'(gt), int'(e.gt));
        chk("z", int'(z), int'(e.eq));
        chk("latency_cycle", cyc, e.due);
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  initial begin
    logic [W-1:0] ra, rb;
    int n;

    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_flags", int'({eq, lt, gt, z}), 0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Test 1: equal operands, full-length scan
    drive(1'b1, 8'h5A, 8'h5A, 1'b0);
    drive(1'b0, 8'h5A, 8'h5A, 1'b0);
    chk("t1_busy_scan", int'(busy), 1);
    wait_idle();

    // Tests 2/3: unsigned and signed orders
    drive(1'b1, 8'h80, 8'h7F, 1'b0); wait_idle();
    drive(1'b1, 8'h12, 8'h13, 1'b0); wait_idle();
    drive(1'b1, 8'h80, 8'h7F, 1'b1); wait_idle();
    drive(1'b1, 8'hFE, 8'hFF, 1'b1); wait_idle();

    // Test 4: inputs change and start re-pulsed during scan
    drive(1'b1, 8'h01, 8'h00, 1'b0);
    drive(1'b1, 8'h00, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 1'b1);
    drive(1'b1, 8'h00, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);

    // Test 5: start in the done cycle, flags held until the new decision
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!done && n < 20);
    chk("t5_done_timeout", int'(n >= 20), 0);
    start = 1'b1; R1 = 8'h00; R2 = 8'hFF; signed_mode = 1'b0;
    if (!busy) sb.push_back(model(8'h00, 8'hFF, 1'b0, cyc));
    drive(1'b0, 8'h00, 8'hFF, 1'b0);
    chk("t5_busy_no_gap", int'(busy), 1);
    chk("t5_gt_held", int'({eq, lt, gt}), 3'b001);
    wait_idle();

    // Test 6: reset mid-scan at idx 2
    drive(1'b1, 8'h33, 8'h33, 1'b0);
    drive(1'b0, 8'h33, 8'h33, 1'b0);
    drive(1'b0, 8'h33, 8'h33, 1'b0);
    drive(1'b0, 8'h33, 8'h33, 1'b0);
    Rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_done", int'(done), 0);
    chk("t6_rst_flags", int'({eq, lt, gt, z}), 0);
    sb.delete();
    @(negedge Clk);
    Rst_n = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    chk("t6_no_done_after_rst", int'(done), 0);
    drive(1'b1, 8'hC0, 8'h3F, 1'b1);
    wait_idle();

    // Randomised traffic with mid-scan operand noise and held start
    for (int i = 0; i < 400; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = (ra & 8'hF0) | (rb & 8'h0F);
        default: ;
      endcase
      drive(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)));
    end
    start = 1'b0;
    wait_idle();
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/comp_serial_unit.md
Name: comp_serial_unit

Overview:
Parametrised multi-cycle magnitude comparator for the datapath; successor to the single-flag zero comparator. It captures two WIDTH-bit operands on a start pulse and compares them CHUNK bits per cycle, MSB first. It terminates as soon as a differing chunk is found and reports registered eq/lt/gt flags plus a legacy zero flag z. It supports unsigned and two's-complement signed modes and sits between the AC register and the bus for branch and condition evaluation.

Parameters:
WIDTH, 8, operand width in bits; legal values are WIDTH >= 2.
CHUNK, 2, bits compared per cycle; legal values are 1..WIDTH and must divide WIDTH exactly. NCH = WIDTH/CHUNK.

Ports:
Clk  input  1  clock, rising-edge.
Rst_n  input  1  asynchronous active-low reset.
start  input  1  request to capture operands; honoured only while busy=0.
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured with the operands.
R1  input  WIDTH  operand A (AC).
R2  input  WIDTH  operand B (bus).
busy  output  1  comparison in progress.
done  output  1  one-cycle pulse: result flags updated this cycle.
eq  output  1  R1 == R2 (registered, held).
lt  output  1  R1 < R2 under the captured mode (registered, held).
gt  output  1  R1 > R2 under the captured mode (registered, held).
z  output  1  alias of eq, kept for compatibility with existing AC zero-flag users.

Behaviour:
- Reset (async, Rst_n=0): busy=0, done=0, eq=lt=gt=z=0, FSM=IDLE, chunk index=0, operand registers=0. Reset takes effect immediately, including mid-scan; the aborted comparison never produces done.
- FSM states:
  - IDLE: at the rising edge with start=1, capture R1, R2 and signed_mode into internal registers, set idx=0, busy=1, and go to SCAN.
  - SCAN: evaluate one chunk per cycle. idx=0 selects the most-significant chunk.
- Per-cycle decision in SCAN, for captured operands A and B:
  - At idx=0 with signed_mode=1 and A[WIDTH-1] != B[WIDTH-1]: decided. lt=A[WIDTH-1], gt=~A[WIDTH-1].
  - Otherwise compare chunk idx of A and B as unsigned. If they differ: decided, with lt/gt set by the chunk compare. Equal sign bits make unsigned chunk order valid for signed mode.
  - If the chunks are equal and idx < NCH-1: idx increments and the unit stays in SCAN.
  - If the chunks are equal and idx == NCH-1: decided, with eq=1.
- On the decision edge:
  - eq/lt/gt/z are written; exactly one of eq/lt/gt is 1.
  - done=1 for the following cycle only.
  - busy=0 and the FSM returns to IDLE.
- Latency: with start sampled at edge E and the decision on chunk i, done and the flags are visible in the cycle after edge E+i+1. Minimum latency is 1 cycle; maximum is NCH cycles (equal operands, or difference only in the last chunk).
- Flags hold their last value until the next decision edge. They are not cleared by start.
- busy is high from the start edge until the decision edge, inclusive of all SCAN cycles.
- Boundary conditions:
  - start while busy=1: ignored, with no queueing.
  - start asserted during the done cycle (busy=0): accepted, giving back-to-back operation with no dead cycle.
  - R1/R2/signed_mode changing during SCAN: no effect, because the operands are captured.
  - start held high continuously: a new comparison begins every time busy returns to 0.
  - CHUNK=WIDTH: every comparison completes in 1 cycle.
  - CHUNK=1: the unit is fully bit-serial.
- Width rules:
  - idx register width is max(1, clog2(NCH)).
  - Chunk select is A[WIDTH-1-idx*CHUNK -: CHUNK].
  - No arithmetic is performed on the full WIDTH, so there is no carry chain.

Test Plan:
1. WIDTH=8, CHUNK=2, unsigned, R1=0x5A, R2=0x5A, start 1 cycle -> busy for 4 cycles, then done pulse with eq=1, z=1, lt=gt=0.
2. Unsigned R1=0x80, R2=0x7F -> decided at chunk 0, done 1 cycle after start, gt=1. Then unsigned R1=0x12, R2=0x13 -> done after 4 cycles, lt=1.
3. Signed R1=0x80 (-128), R2=0x7F -> done after 1 cycle, lt=1. Then signed R1=0xFE (-2), R2=0xFF (-1) -> done after 4 cycles, lt=1.
4. Unsigned R1=0x01, R2=0x00 -> gt. During SCAN, change R1 to 0x00 and pulse start repeatedly -> result still gt, a single done, and the extra starts are ignored.
5. Assert start again in the done cycle with R1=0x00, R2=0xFF, unsigned -> new scan begins with no gap. Previous flags stay held until the new done, which shows lt=1 after 1 cycle.
6. Rst_n low for 1 cycle at scan idx=2 -> busy, done, eq, lt, gt and z go to 0 immediately, and no done follows. A new start after reset compares correctly.
